// File: rtl/dp_data_mem_port.sv
// Data-memory responder: word RAM behind a fixed wait-state valid/ready port.
// Define MEM_ALIGN_CHECK_EN to add err_out and misaligned/out-of-range faulting.
module dp_data_mem_port #(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] data_out
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        err_out
`endif
);

    localparam int          DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES);
    localparam logic [31:0] HI_MASK  = ~((32'd1 << (ADDR_W + 2)) - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                write_q, write_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         dout_q, dout_d;
    logic                err_q, err_d;

    logic [31:0]         mem_q [DEPTH];

    logic [ADDR_W-1:0]   acc_idx;
    logic                acc_write;
    logic [31:0]         acc_wdata;
    logic                acc_fault;
    logic                commit;
    logic                mem_we;

    // With zero wait states the access commits on the accepting edge,
    // so the live request is used there instead of the latched copy.
    assign acc_idx   = (state_q == S_IDLE) ? addr_in[ADDR_W+1:2] : idx_q;
    assign acc_write = (state_q == S_IDLE) ? req_write : write_q;
    assign acc_wdata = (state_q == S_IDLE) ? wdata_in : wdata_q;

`ifdef MEM_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic in_fault;

    assign in_fault  = (addr_in[1:0] != 2'b00) ||
                       ((addr_in & HI_MASK) != 32'h0);
    assign acc_fault = (state_q == S_IDLE) ? in_fault : fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    always_comb begin
        fault_d = fault_q;
        if (state_q == S_IDLE && req_valid) begin
            fault_d = in_fault;
        end
    end

    assign err_out = err_q;
`else
    logic unused_addr;

    assign unused_addr = ^{addr_in[31:ADDR_W+2], addr_in[1:0], HI_MASK[0]};
    assign acc_fault   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    idx_d   = addr_in[ADDR_W+1:2];
                    write_d = req_write;
                    wdata_d = wdata_in;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign commit = (state_d == S_DONE) && (state_q != S_DONE);
    assign mem_we = commit && acc_write && !acc_fault && !rst;

    always_comb begin
        dout_d = dout_q;
        err_d  = commit && acc_fault;
        if (commit && !acc_write) begin
            dout_d = acc_fault ? 32'h0 : mem_q[acc_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= 32'h0;
            dout_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign data_out   = dout_q;

endmodule

// File: tb/tb_dp_data_mem_port.sv
// Directed bench for dp_data_mem_port: WAIT_CYCLES=2 instance plus a zero-wait one.
// Alignment vectors are selected when MEM_ALIGN_CHECK_EN is defined.
module tb_dp_data_mem_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_valid = 1'b0, a_write = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0;
    logic        a_ready, a_resp;
    logic [31:0] a_dout;

    logic        b_valid = 1'b0, b_write = 1'b0;
    logic [31:0] b_addr = '0, b_wdata = '0;
    logic        b_ready, b_resp;
    logic [31:0] b_dout;

`ifdef MEM_ALIGN_CHECK_EN
    logic        a_err, b_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dp_data_mem_port #(.ADDR_W(6), .WAIT_CYCLES(2)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .req_valid (a_valid),
        .req_write (a_write),
        .addr_in   (a_addr),
        .wdata_in  (a_wdata),
        .req_ready (a_ready),
        .resp_valid(a_resp),
        .data_out  (a_dout)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .err_out   (a_err)
`endif
    );

    dp_data_mem_port #(.ADDR_W(6), .WAIT_CYCLES(0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .req_valid (b_valid),
        .req_write (b_write),
        .addr_in   (b_addr),
        .wdata_in  (b_wdata),
        .req_ready (b_ready),
        .resp_valid(b_resp),
        .data_out  (b_dout)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .err_out   (b_err)
`endif
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_dout;
        logic        exp_err;
    } vec_t;

    vec_t vec[$];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic a_err_now();
`ifdef MEM_ALIGN_CHECK_EN
        return a_err;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic b_err_now();
`ifdef MEM_ALIGN_CHECK_EN
        return b_err;
`else
        return 1'b0;
`endif
    endfunction

    // Issue one request on dut_a; lat = cycle index after acceptance of the pulse.
    task automatic a_access(input logic wr, input logic [31:0] ad,
                            input logic [31:0] wd, output int lat,
                            output logic [31:0] dv, output logic ev,
                            output logic rdy);
        int guard;
        guard = 0;
        lat = -1; dv = '0; ev = 1'b0; rdy = 1'b1;
        @(negedge clk);
        while (!a_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        a_valid = 1'b1; a_write = wr; a_addr = ad; a_wdata = wd;
        @(negedge clk);
        a_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (a_resp) begin
                lat = c; dv = a_dout; ev = a_err_now(); rdy = a_ready;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic b_access(input logic wr, input logic [31:0] ad,
                            input logic [31:0] wd, output int lat,
                            output logic [31:0] dv);
        lat = -1; dv = '0;
        @(negedge clk);
        b_valid = 1'b1; b_write = wr; b_addr = ad; b_wdata = wd;
        @(negedge clk);
        b_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (b_resp) begin
                lat = c; dv = b_dout;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat, nres;
        logic [31:0] dv;
        logic        ev, rdy;

        vec.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0});
        vec.push_back('{1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0});
        vec.push_back('{1'b1, 32'h3C, 32'h00001234, 32'hDEADBEEF, 1'b0});
        vec.push_back('{1'b1, 32'h20, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0});
        vec.push_back('{1'b0, 32'h3C, 32'h0,        32'h00001234, 1'b0});
        vec.push_back('{1'b0, 32'h20, 32'h0,        32'hCAFEF00D, 1'b0});
        vec.push_back('{1'b1, 32'hFC, 32'hFFFFFFFF, 32'hCAFEF00D, 1'b0});
        vec.push_back('{1'b0, 32'hFC, 32'h0,        32'hFFFFFFFF, 1'b0});
`ifdef MEM_ALIGN_CHECK_EN
        vec.push_back('{1'b1, 32'h0,   32'h11, 32'hFFFFFFFF, 1'b0});
        vec.push_back('{1'b0, 32'h12,  32'h0,  32'h0,        1'b1});
        vec.push_back('{1'b1, 32'h200, 32'hFF, 32'h0,        1'b1});
        vec.push_back('{1'b0, 32'h0,   32'h0,  32'h11,       1'b0});
`else
        vec.push_back('{1'b1, 32'h100, 32'hA5, 32'hFFFFFFFF, 1'b0});
        vec.push_back('{1'b0, 32'h0,   32'h0,  32'hA5,       1'b0});
        vec.push_back('{1'b0, 32'h103, 32'h0,  32'hA5,       1'b0});
`endif

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(a_ready), 32'd1);
        chk("rst_resp", 32'(a_resp), 32'd0);
        chk("rst_dout", a_dout, 32'h0);
        chk("rst_err", 32'(a_err_now()), 32'd0);

        foreach (vec[i]) begin
            a_access(vec[i].wr, vec[i].addr, vec[i].wdata, lat, dv, ev, rdy);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'd3);
            chk($sformatf("v%0d_dout", i), dv, vec[i].exp_dout);
            chk($sformatf("v%0d_busy", i), 32'(rdy), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
            chk($sformatf("v%0d_err", i), 32'(ev), 32'(vec[i].exp_err));
`endif
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), 32'(a_resp), 32'd0);
            chk($sformatf("v%0d_hold", i), a_dout, vec[i].exp_dout);
            chk($sformatf("v%0d_err_lo", i), 32'(a_err_now()), 32'd0);
        end

        // req_valid held through WAIT/DONE with a different address.
        @(negedge clk);
        a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h4; a_wdata = 32'h1;
        @(negedge clk);
        a_addr = 32'h3C; a_wdata = 32'h77;
        nres = 0;
        for (int c = 1; c <= 3; c++) begin
            if (a_resp) nres++;
            if (c < 3) @(negedge clk);
        end
        a_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (a_resp) nres++;
        end
        chk("held_one_resp", 32'(nres), 32'd1);

        a_access(1'b0, 32'h4, 32'h0, lat, dv, ev, rdy);
        chk("b2b_lat", 32'(lat), 32'd3);
        chk("b2b_data", dv, 32'h1);
        a_access(1'b0, 32'h3C, 32'h0, lat, dv, ev, rdy);
        chk("ignored_req", dv, 32'h00001234);

        // Reset in WAIT of a store: discarded, outputs clear asynchronously.
        a_access(1'b1, 32'h8, 32'h0, lat, dv, ev, rdy);
        chk("zero_store_lat", 32'(lat), 32'd3);
        @(negedge clk);
        a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h8; a_wdata = 32'h55;
        @(negedge clk);
        a_valid = 1'b0;
        chk("wait_busy", 32'(a_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_ready", 32'(a_ready), 32'd1);
        chk("async_resp", 32'(a_resp), 32'd0);
        chk("async_dout", a_dout, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        nres = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (a_resp) nres++;
        end
        chk("rst_no_resp", 32'(nres), 32'd0);
        a_access(1'b0, 32'h8, 32'h0, lat, dv, ev, rdy);
        chk("rst_store_lost", dv, 32'h0);

        // Zero wait states.
        b_access(1'b1, 32'h8, 32'h99, lat, dv);
        chk("w0_store_lat", 32'(lat), 32'd1);
        chk("w0_busy", 32'(b_ready), 32'd0);
        @(negedge clk);
        chk("w0_pulse", 32'(b_resp), 32'd0);
        chk("w0_ready", 32'(b_ready), 32'd1);
        chk("w0_err_lo", 32'(b_err_now()), 32'd0);
        b_access(1'b0, 32'h8, 32'h0, lat, dv);
        chk("w0_load_lat", 32'(lat), 32'd1);
        chk("w0_load_data", dv, 32'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
